// File: rtl/flag_unit.sv
// flag_unit: architectural Z/V/N flag register fed from the EX-stage ALU,
// with the ID conditional-branch interlock and the sticky halt latch.
module flag_unit #(
  parameter int DATA_W = 16,
  parameter int OPC_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_hold,
  input  logic [OPC_W-1:0]  ex_opcode,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_ovfl,
  input  logic [1:0]        id_branch,
  input  logic [2:0]        id_cond,
  output logic [2:0]        flags,
  output logic              branch_stall,
  output logic              halted
);

  localparam logic [OPC_W-1:0] OPC_ADD = OPC_W'(4'h0);
  localparam logic [OPC_W-1:0] OPC_SUB = OPC_W'(4'h1);
  localparam logic [OPC_W-1:0] OPC_XOR = OPC_W'(4'h2);
  localparam logic [OPC_W-1:0] OPC_SLL = OPC_W'(4'h4);
  localparam logic [OPC_W-1:0] OPC_SRA = OPC_W'(4'h5);
  localparam logic [OPC_W-1:0] OPC_ROR = OPC_W'(4'h6);
  localparam logic [OPC_W-1:0] OPC_HLT = OPC_W'(4'hF);
  localparam logic [2:0]       COND_ALWAYS = 3'b111;

  // Arithmetic ops own all three flags.
  function automatic logic writes_zvn(input logic [OPC_W-1:0] opc);
    return (opc == OPC_ADD) || (opc == OPC_SUB);
  endfunction

  // Logic/shift ops only touch Z; V and N carry over.
  function automatic logic writes_z_only(input logic [OPC_W-1:0] opc);
    return (opc == OPC_XOR) || (opc == OPC_SLL) ||
           (opc == OPC_SRA) || (opc == OPC_ROR);
  endfunction

  function automatic logic writes_flags(input logic [OPC_W-1:0] opc);
    return writes_zvn(opc) || writes_z_only(opc);
  endfunction

  logic signed [DATA_W-1:0] res_s;
  logic                     z_new;
  logic                     n_new;
  logic                     ex_adv;
  logic                     upd;
  logic                     unused_br_reg;

  // The result is consumed as a signed quantity: N is simply its sign.
  assign res_s  = ex_result;
  assign z_new  = (res_s == '0);
  assign n_new  = (res_s < 0);
  assign ex_adv = ex_valid & ~ex_hold;
  assign upd    = ex_adv & ~halted & writes_flags(ex_opcode);

  // Register target vs. immediate target is irrelevant to the flag hazard.
  assign unused_br_reg = id_branch[0];

  // Stall a conditional branch in ID while EX still owes it flags; the
  // bubble that follows clears the condition, so the stall is one cycle.
  assign branch_stall = id_branch[1] & (id_cond != COND_ALWAYS) & ex_valid &
                        ~halted & writes_flags(ex_opcode);

  // Flag register and halt latch, updated as EX instructions retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags  <= 3'b000;
      halted <= 1'b0;
    end else begin
      if (upd) begin
        flags[2] <= z_new;
        if (writes_zvn(ex_opcode)) begin
          flags[1] <= ex_ovfl;
          flags[0] <= n_new;
        end
      end
      if (ex_adv && (ex_opcode == OPC_HLT)) begin
        halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_flag_unit.sv
// tb_flag_unit: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a table-driven flag model.
module tb_flag_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_hold;
  logic [3:0]  ex_opcode;
  logic [15:0] ex_result;
  logic        ex_ovfl;
  logic [1:0]  id_branch;
  logic [2:0]  id_cond;
  logic [2:0]  flags;
  logic        branch_stall;
  logic        halted;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  // Behavioural model state.
  logic [2:0] m_flags = 3'b000;
  logic       m_halted = 1'b0;
  logic [2:0] wmask [16];

  flag_unit #(.DATA_W(16), .OPC_W(4)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_hold(ex_hold),
    .ex_opcode(ex_opcode), .ex_result(ex_result), .ex_ovfl(ex_ovfl),
    .id_branch(id_branch), .id_cond(id_cond), .flags(flags),
    .branch_stall(branch_stall), .halted(halted)
  );

  always #5 clk = ~clk;

  // Which of {Z,V,N} each opcode is allowed to write.
  initial begin
    for (int i = 0; i < 16; i++) wmask[i] = 3'b000;
    wmask[0] = 3'b111;  // ADD
    wmask[1] = 3'b111;  // SUB
    wmask[2] = 3'b100;  // XOR
    wmask[4] = 3'b100;  // SLL
    wmask[5] = 3'b100;  // SRA
    wmask[6] = 3'b100;  // ROR
  end

  // Model: retiring instructions merge their computed flags through the mask.
  always @(posedge clk) begin
    logic [2:0] nv;
    if (rst) begin
      m_flags  = 3'b000;
      m_halted = 1'b0;
    end else if (ex_valid && !ex_hold) begin
      if (!m_halted) begin
        nv = {ex_result == 16'd0, ex_ovfl, ex_result[15]};
        m_flags = (m_flags & ~wmask[ex_opcode]) | (nv & wmask[ex_opcode]);
      end
      if (ex_opcode == 4'hF) m_halted = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [2:0] got, input logic [2:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    logic exp_stall;
    if (chk_en) begin
      exp_stall = id_branch[1] && (id_cond != 3'b111) && ex_valid &&
                  !m_halted && (wmask[ex_opcode] != 3'b000);
      chk("model_flags", flags, m_flags);
      chk("model_halted", {2'b00, halted}, {2'b00, m_halted});
      chk("model_stall", {2'b00, branch_stall}, {2'b00, exp_stall});
    end
  end

  // Advance one edge, then present a new set of inputs for the next edge.
  task automatic cyc(input logic r, input logic v, input logic h, input logic [3:0] opc,
                     input logic [15:0] res, input logic ov, input logic [1:0] br,
                     input logic [2:0] cond);
    @(posedge clk);
    #2;
    rst = r; ex_valid = v; ex_hold = h; ex_opcode = opc;
    ex_result = res; ex_ovfl = ov; id_branch = br; id_cond = cond;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 1'b0, 2'b00, 3'b000);
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_hold = 1'b0; ex_opcode = 4'h0;
    ex_result = 16'h0; ex_ovfl = 1'b0; id_branch = 2'b00; id_cond = 3'b000;

    // Reset overrides a valid ADD with zero result.
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 16'h0000, 1'b0, 2'b00, 3'b000);
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 16'h0000, 1'b0, 2'b00, 3'b000);
    chk("reset_flags", flags, 3'b000);
    chk("reset_halted", {2'b00, halted}, 3'b000);
    chk_en = 1'b1;
    idle();
    chk("add_zero", flags, 3'b100);

    // ADD negative with overflow, then XOR zero keeps V and N.
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 16'h8000, 1'b1, 2'b00, 3'b000);
    cyc(1'b0, 1'b1, 1'b0, 4'h2, 16'h0000, 1'b0, 2'b00, 3'b000);
    chk("add_neg_ovf", flags, 3'b011);
    idle();
    chk("xor_keeps_vn", flags, 3'b111);

    // Conditional branch against SUB stalls once, then the bubble clears it.
    cyc(1'b0, 1'b1, 1'b0, 4'h1, 16'h0001, 1'b0, 2'b10, 3'b000);
    chk("sub_stall", {2'b00, branch_stall}, 3'b001);
    cyc(1'b0, 1'b0, 1'b0, 4'h1, 16'h0001, 1'b0, 2'b10, 3'b000);
    chk("bubble_no_stall", {2'b00, branch_stall}, 3'b000);
    chk("sub_flags", flags, 3'b000);
    cyc(1'b0, 1'b1, 1'b0, 4'h1, 16'h8000, 1'b0, 2'b11, 3'b111);
    chk("uncond_no_stall", {2'b00, branch_stall}, 3'b000);
    idle();
    chk("sub_neg", flags, 3'b001);

    // Non-writers: no update, no stall.
    cyc(1'b0, 1'b1, 1'b0, 4'h8, 16'h0000, 1'b1, 2'b10, 3'b010);
    chk("lw_no_stall", {2'b00, branch_stall}, 3'b000);
    cyc(1'b0, 1'b1, 1'b0, 4'h7, 16'h0000, 1'b1, 2'b10, 3'b010);
    chk("paddsb_no_stall", {2'b00, branch_stall}, 3'b000);
    cyc(1'b0, 1'b1, 1'b0, 4'h3, 16'h0000, 1'b1, 2'b10, 3'b010);
    idle();
    chk("nonwriters_flags", flags, 3'b001);

    // Hold ADD 5 for three cycles: stall held, flags frozen.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 4'h0, 16'h0005, 1'b0, 2'b10, 3'b001);
      chk("hold_stall", {2'b00, branch_stall}, 3'b001);
      chk("hold_flags", flags, 3'b001);
    end
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 16'h0005, 1'b0, 2'b10, 3'b001);
    chk("hold_flags_last", flags, 3'b001);
    idle();
    chk("hold_release", flags, 3'b000);

    // HLT under hold does not halt until it advances; then flags freeze.
    cyc(1'b0, 1'b1, 1'b1, 4'hF, 16'h0000, 1'b0, 2'b00, 3'b000);
    cyc(1'b0, 1'b1, 1'b0, 4'hF, 16'h0000, 1'b0, 2'b00, 3'b000);
    chk("hlt_held", {2'b00, halted}, 3'b000);
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 16'h0000, 1'b1, 2'b10, 3'b000);
    chk("halted_set", {2'b00, halted}, 3'b001);
    chk("halted_no_stall", {2'b00, branch_stall}, 3'b000);
    idle();
    chk("halted_frozen", flags, 3'b000);
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 2'b00, 3'b000);
    idle();
    chk("halt_cleared", {2'b00, halted}, 3'b000);

    // Random traffic checked by the model each cycle.
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] res;
      logic [3:0]  opc;
      case ($urandom_range(0, 3))
        0: res = 16'h0000;
        1: res = 16'h8000;
        2: res = 16'h7FFF;
        default: res = 16'($urandom);
      endcase
      opc = ($urandom_range(0, 24) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 3) == 0), opc, res, 1'($urandom),
          2'($urandom), 3'($urandom));
    end
    idle();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Producer end of the flag interface that feeds next-PC selection: holds the architectural Z/V/N flags and presents them as F[2:0] = {Z,V,N} to branch resolution in ID.
- Flags are computed from the EX-stage ALU result and opcode class, then registered at the end of EX.
- Raises a one-cycle branch interlock when an ID conditional branch would read flags still being produced in EX.
- Latches HLT so flags freeze after the halting instruction retires from EX.

Parameters:
DATA_W, 16, ALU result width
OPC_W, 4, opcode width

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  synchronous, active-high reset
ex_valid  input  1  EX stage holds a valid (non-bubble) instruction
ex_hold  input  1  pipeline freeze; EX instruction does not advance this cycle
ex_opcode  input  OPC_W  opcode of EX instruction
ex_result  input  DATA_W  ALU result (post-saturation) of EX instruction
ex_ovfl  input  1  signed-overflow indication from ALU for ADD/SUB
id_branch  input  2  ID branch field: bit1 = branch instr, bit0 = BR (register target)
id_cond  input  3  ID branch condition code
flags  output  3  registered {Z,V,N}, drives branch flag input
branch_stall  output  1  stall IF/ID one cycle, insert bubble into EX
halted  output  1  HLT has retired from EX

Behaviour:
- Reset (rst=1 at posedge): flags=3'b000, halted=0. rst overrides all other inputs in the same cycle. branch_stall is combinational, so it reads 0 whenever ex_valid=0.
- Opcode classes:
  - ADD 0000, SUB 0001: write Z, V, N.
  - XOR 0010, SLL 0100, SRA 0101, ROR 0110: write Z only; V and N hold.
  - All other opcodes write no flags: RED, PADDSB, LW, SW, LLB, LHB, B, BR, PCS, HLT.
- Flag values:
  - Z = (ex_result == 0).
  - N = ex_result[DATA_W-1].
  - V = ex_ovfl.
  - Saturated results are used as-is; for example, saturated 16'h7FFF gives N=0, V=1.
- Update enable: upd = ex_valid & !ex_hold & !halted & writes_flags(ex_opcode).
  - On posedge with upd=1, the written fields load; unwritten fields keep their value.
  - Latency: flags reflect the EX instruction on the cycle after it leaves EX.
- Interlock: branch_stall = id_branch[1] & (id_cond != 3'b111) & ex_valid & !halted & writes_flags(ex_opcode).
  - There is no combinational bypass; flags are registered only.
  - Unconditional branches (cond 111) never stall.
  - While ex_hold=1, branch_stall keeps evaluating on current EX contents; the pipeline freeze takes priority.
  - A stall lasts exactly one cycle, since the bubble leaves EX with ex_valid=0.
- Halt: posedge with ex_valid & !ex_hold & ex_opcode==4'b1111 sets halted=1.
  - halted is sticky until rst.
  - While halted, flags never update and branch_stall=0.
- HLT held under ex_hold does not set halted until the cycle it advances.
- Back-to-back flag writers update each cycle; the last one to leave EX wins.
- Bubble (ex_valid=0) with a flag-setting opcode present on ex_opcode causes no update and no stall.

Test Plan:
- Reset: drive rst=1 with ex_valid=1, ADD, result 0 -> after posedge flags=000, halted=0; release -> next ADD result 0 sets flags=100.
- ADD result 16'h8000, ovfl=1 -> flags=011. Then XOR result 16'h0000 -> flags=111, with V and N retained.
- SUB in EX with ID branch cond 000 -> branch_stall=1 that cycle. Next cycle, EX bubble -> branch_stall=0 and flags show SUB's result. Same setup with cond 111 -> branch_stall=0.
- LW/PADDSB/RED in EX with result 0 -> flags unchanged, and no stall on an ID conditional branch.
- ex_hold=1 for 3 cycles with ADD result 5 in EX -> flags unchanged and branch_stall held 1. Hold drops -> flags=000 on the next edge.
- HLT retires -> halted=1. A subsequent ADD result 0 -> flags unchanged. rst -> halted=0.
